circular_bist_top: RTL and testbench

//  - Wraps a 4-requester round-robin arbiter (the circuit under test, CUT) with circular self-test.
//  - In mission mode it arbitrates request1..4 onto a one-hot grant.
//  - In BIST mode the CUT flip-flops become a 16-bit circular BIST register (CBR). The CBR

---
 rtl/circular_bist_pkg.sv | 57 +++++
 rtl/circular_bist_if.sv | 36 +++
 rtl/cbist_rr_arbiter.sv | 62 ++++++
 rtl/circular_bist.sv | 116 +++++++++++
 tb/tb_circular_bist_top.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/circular_bist_pkg.sv
// ---------------------------------------------------------------------------
// circular_bist_pkg
//  Shared definitions for the circular-BIST wrapped round-robin arbiter:
//   - controller state encoding and register-bank operating modes
//   - circular BIST register (CBR) width and cell-field positions
//   - rr_pick(): round-robin winner selection, shared by the mission-mode
//     next-state logic and the self-test excitation
// ---------------------------------------------------------------------------
package circular_bist_pkg;

    localparam int CBR_W    = 16;
    localparam int FIELD_W  = 4;
    localparam int REQ_LSB  = 0;   // [3:0]   registered requests
    localparam int GNT_LSB  = 4;   // [7:4]   grant register
    localparam int LAST_LSB = 8;   // [11:8]  last_granted register
    localparam int PAD_LSB  = 12;  // [15:12] pad cells, functional next-state 0

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_TEST,
        ST_DONE
    } bist_state_e;

    // How the register bank updates on the next clock.
    typedef enum logic [1:0] {
        MODE_MISSION,  // normal arbitration
        MODE_LOAD,     // load the BIST seed
        MODE_TEST,     // circular self-excitation
        MODE_HOLD      // freeze contents
    } cbr_mode_e;

    // Search starts one position above the highest set bit of last, wrapping
    // 3 -> 0. An all-zero last (post reset) starts the search at request1.
    // In self-test last can hold any pattern, so the rule is defined for all
    // 16 values, not just one-hot ones.
    function automatic logic [FIELD_W-1:0] rr_pick(
        input logic [FIELD_W-1:0] req,
        input logic [FIELD_W-1:0] last
    );
        logic [1:0]         start;
        logic [1:0]         idx;
        logic [FIELD_W-1:0] win;
        start = 2'd0;
        for (int i = 0; i < FIELD_W; i++) begin
            if (last[i]) start = 2'(i + 1);
        end
        win = '0;
        // Walk from the farthest offset down so the nearest active request wins.
        for (int k = FIELD_W - 1; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) win = 4'b0001 << idx;
        end
        return win;
    endfunction

endpackage

// File: rtl/circular_bist_if.sv
// ---------------------------------------------------------------------------
// circular_bist_if
//  Functional and production-test signals of circular_bist_top.
//   request1..4   requests, request1 = index 0
//   grant_o       one-hot grant, bit0 = request1
//   bist_start    rising edge starts a BIST run
//   bist_end      run complete, held until reset or next start
//   signature_out final CBR contents, valid while bist_end = 1
//   pass_fail     signature_out == golden signature, valid while bist_end = 1
//  master: drives requests and bist_start (test equipment / system side)
//  slave:  the BIST-wrapped arbiter
// ---------------------------------------------------------------------------
interface circular_bist_if;
    import circular_bist_pkg::*;

    logic               request1;
    logic               request2;
    logic               request3;
    logic               request4;
    logic [FIELD_W-1:0] grant_o;
    logic               bist_start;
    logic               bist_end;
    logic [CBR_W-1:0]   signature_out;
    logic               pass_fail;

    modport master (
        output request1, request2, request3, request4, bist_start,
        input  grant_o, bist_end, signature_out, pass_fail
    );

    modport slave (
        input  request1, request2, request3, request4, bist_start,
        output grant_o, bist_end, signature_out, pass_fail
    );

endinterface

// File: rtl/cbist_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cbist_rr_arbiter
//  4-input round-robin arbiter whose 16 flip-flops double as the circular
//  BIST register. Cell map: [3:0] req_q, [7:4] grant, [11:8] last_granted,
//  [15:12] pad.
//  Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   mode          bank update mode (mission / load seed / test / hold)
//   req           external requests, bit0 = request1 (ignored outside mission)
//   seed          value loaded in MODE_LOAD
//   cbr           current register contents
//   cbr_next      contents after the coming clock edge
// ---------------------------------------------------------------------------
module cbist_rr_arbiter
    import circular_bist_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  cbr_mode_e            mode,
    input  logic [FIELD_W-1:0]   req,
    input  logic [CBR_W-1:0]     seed,
    output logic [CBR_W-1:0]     cbr,
    output logic [CBR_W-1:0]     cbr_next
);

    logic [CBR_W-1:0]   func;
    logic [FIELD_W-1:0] pick;

    // Functional next-state of every cell, computed from the bank itself.
    // The request cells take 0 here; mission mode substitutes the real inputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        func = '0;
        pick = rr_pick(cbr[REQ_LSB +: FIELD_W], cbr[LAST_LSB +: FIELD_W]);
        func[GNT_LSB +: FIELD_W]  = pick;
        func[LAST_LSB +: FIELD_W] = (pick != '0) ? pick : cbr[LAST_LSB +: FIELD_W];
    end

    always_comb begin
        cbr_next = cbr;
        unique case (mode)
            MODE_MISSION: begin
                cbr_next = func;
                cbr_next[REQ_LSB +: FIELD_W] = req;
            end
            MODE_LOAD: cbr_next = seed;
            // Cell i takes f_i XOR q[i-1]; cell 0 closes the ring from cell 15.
            MODE_TEST: cbr_next = func ^ {cbr[CBR_W-2:0], cbr[CBR_W-1]};
            MODE_HOLD: cbr_next = cbr;
            default:   cbr_next = cbr;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge.
        if (reset) cbr <= '0;
        else       cbr <= cbr_next;
    end

endmodule

// File: rtl/circular_bist.sv
// ---------------------------------------------------------------------------
// circular_bist_top
//  Round-robin arbiter (CUT) wrapped with circular self-test. In mission mode
//  request1..4 are arbitrated onto a one-hot grant with 2-clock latency. A
//  rising edge on bist_start turns the CUT registers into a 16-bit circular
//  BIST register, seeds it, runs BIST_CYCLES clocks and reports the final
//  contents and a golden-signature compare.
//  Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-high, clears all state
//   bus    circular_bist_if.slave (requests, grant, BIST start/end/result)
//  Parameters:
//   BIST_CYCLES  test clocks after seeding
//   INIT_SEED    CBR seed
//   GOLDEN_SIG   characterised fault-free signature
// ---------------------------------------------------------------------------
module circular_bist_top
    import circular_bist_pkg::*;
#(
    parameter int               BIST_CYCLES = 255,
    parameter logic [CBR_W-1:0] INIT_SEED   = 16'hFFFF,
    parameter logic [CBR_W-1:0] GOLDEN_SIG  = 16'h0000
)(
    input  logic             clock,
    input  logic             reset,
    circular_bist_if.slave   bus
);

    localparam int CNT_W = (BIST_CYCLES > 1) ? $clog2(BIST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIST_CYCLES - 1);

    bist_state_e       state;
    cbr_mode_e         mode;
    logic              start_q;
    logic              start_qq;
    logic              start_edge;
    logic [CNT_W-1:0]  cycle_cnt;
    logic              bist_end_q;
    logic              pass_fail_q;
    logic [CBR_W-1:0]  signature_q;
    logic [CBR_W-1:0]  cbr;
    logic [CBR_W-1:0]  cbr_next;

    cbist_rr_arbiter u_arb (
        .clock    (clock),
        .reset    (reset),
        .mode     (mode),
        .req      ({bus.request4, bus.request3, bus.request2, bus.request1}),
        .seed     (INIT_SEED),
        .cbr      (cbr),
        .cbr_next (cbr_next)
    );

    // Edge of the registered start, so a level held high starts one run only.
    assign start_edge = start_q & ~start_qq;

    always_comb begin
        mode = MODE_HOLD;
        unique case (state)
            ST_IDLE: mode = MODE_MISSION;
            ST_INIT: mode = MODE_LOAD;
            ST_TEST: mode = MODE_TEST;
            ST_DONE: mode = MODE_HOLD;
            default: mode = MODE_HOLD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            start_qq    <= 1'b0;
            cycle_cnt   <= '0;
            bist_end_q  <= 1'b0;
            pass_fail_q <= 1'b0;
            signature_q <= '0;
        end else begin
            start_q  <= bus.bist_start;
            start_qq <= start_q;
            unique case (state)
                ST_IDLE: begin
                    if (start_edge) state <= ST_INIT;
                end
                ST_INIT: begin
                    cycle_cnt  <= '0;
                    bist_end_q <= 1'b0;
                    state      <= ST_TEST;
                end
                ST_TEST: begin
                    // Start edges are ignored here. The last test clock also
                    // captures the result, so the signature is the CBR after
                    // exactly BIST_CYCLES steps.
                    if (cycle_cnt == CNT_LAST) begin
                        signature_q <= cbr_next;
                        pass_fail_q <= (cbr_next == GOLDEN_SIG);
                        bist_end_q  <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start_edge) state <= ST_INIT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The grant register carries test patterns outside IDLE, so it is masked.
    assign bus.grant_o       = (state == ST_IDLE) ? cbr[GNT_LSB +: FIELD_W] : '0;
    assign bus.bist_end      = bist_end_q;
    assign bus.signature_out = signature_q;
    assign bus.pass_fail     = pass_fail_q;

endmodule

// File: tb/tb_circular_bist_top.sv
// ---------------------------------------------------------------------------
// tb_circular_bist_top
//  Two instances share one stimulus: dut_a with default parameters, dut_b
//  with a 3-cycle run and its golden signature set to the value worked out
//  by hand (seed FFFF -> FEEF -> FCCF -> F88F).
// ---------------------------------------------------------------------------
module tb_circular_bist_top;

    localparam int          CYC_A  = 255;
    localparam int          CYC_B  = 3;
    localparam logic [15:0] SEED   = 16'hFFFF;
    localparam logic [15:0] GOLD_A = 16'h0000;
    localparam logic [15:0] GOLD_B = 16'hF88F;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic       start;

    int n_cmp;
    int n_fail;

    circular_bist_if bus_a ();
    circular_bist_if bus_b ();

    assign bus_a.request1 = req[0];
    assign bus_a.request2 = req[1];
    assign bus_a.request3 = req[2];
    assign bus_a.request4 = req[3];
    assign bus_a.bist_start = start;
    assign bus_b.request1 = req[0];
    assign bus_b.request2 = req[1];
    assign bus_b.request3 = req[2];
    assign bus_b.request4 = req[3];
    assign bus_b.bist_start = start;

    circular_bist_top #(.BIST_CYCLES(CYC_A), .INIT_SEED(SEED), .GOLDEN_SIG(GOLD_A)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    circular_bist_top #(.BIST_CYCLES(CYC_B), .INIT_SEED(SEED), .GOLDEN_SIG(GOLD_B)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference CBR step: cell i = functional next-state XOR cell i-1.
    function automatic logic [15:0] model_step(input logic [15:0] q);
        logic [3:0]  rq;
        logic [3:0]  last;
        logic [3:0]  win;
        logic [15:0] f;
        int          first;
        rq   = q[3:0];
        last = q[11:8];
        if      (last[3]) first = 0;
        else if (last[2]) first = 3;
        else if (last[1]) first = 2;
        else if (last[0]) first = 1;
        else              first = 0;
        win = 4'b0000;
        for (int off = 0; off < 4; off++) begin
            if (win == 4'b0000 && rq[(first + off) % 4]) win[(first + off) % 4] = 1'b1;
        end
        f = 16'h0000;
        f[7:4]  = win;
        f[11:8] = (win != 4'b0000) ? win : last;
        return f ^ {q[14:0], q[15]};
    endfunction

    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] q;
        q = SEED;
        for (int i = 0; i < n; i++) q = model_step(q);
        return q;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One start pulse; latencies are counted in clocks from the edge that
    // registers the pulse to the first clock where bist_end is seen rising.
    // glitch_at > 0 re-pulses start at that clock count.
    task automatic run_bist(input int glitch_at, output int lat_a, output int lat_b);
        logic prev_a;
        logic prev_b;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start  = 1'b0;
        prev_a = bus_a.bist_end;
        prev_b = bus_b.bist_end;
        lat_a  = -1;
        lat_b  = -1;
        for (int c = 1; c <= CYC_A + 40; c++) begin
            @(posedge clock);
            #1;
            if (lat_a < 0 && bus_a.bist_end && !prev_a) lat_a = c;
            if (lat_b < 0 && bus_b.bist_end && !prev_b) lat_b = c;
            prev_a = bus_a.bist_end;
            prev_b = bus_b.bist_end;
            if (c == 10) begin
                check("grant_masked_a", 32'(bus_a.grant_o), 32'h0);
                check("grant_masked_b", 32'(bus_b.grant_o), 32'h0);
            end
            start = (c == glitch_at);
            if (lat_a >= 0 && lat_b >= 0 && c > glitch_at + 10) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
    } vec_t;

    localparam int NV = 16;
    vec_t       vecs [NV];
    logic [3:0] exp_q [$];
    logic [3:0] e;
    logic [15:0] s_full;
    int lat_a;
    int lat_b;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        req    = 4'b0000;
        start  = 1'b0;
        s_full = model_sig(CYC_A);

        // Arbitration sequence from reset, each vector held one clock.
        vecs[0]  = '{4'b1111, 4'b0001};
        vecs[1]  = '{4'b1111, 4'b0010};
        vecs[2]  = '{4'b1111, 4'b0100};
        vecs[3]  = '{4'b1111, 4'b1000};
        vecs[4]  = '{4'b1111, 4'b0001};
        vecs[5]  = '{4'b0000, 4'b0000};
        vecs[6]  = '{4'b0010, 4'b0010};
        vecs[7]  = '{4'b0010, 4'b0010};
        vecs[8]  = '{4'b0010, 4'b0010};
        vecs[9]  = '{4'b1001, 4'b1000};
        vecs[10] = '{4'b1001, 4'b0001};
        vecs[11] = '{4'b0110, 4'b0010};
        vecs[12] = '{4'b0101, 4'b0100};
        vecs[13] = '{4'b0101, 4'b0001};
        vecs[14] = '{4'b1000, 4'b1000};
        vecs[15] = '{4'b0000, 4'b0000};

        // Reset values, sampled while reset is held.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_grant",     32'(bus_a.grant_o), 32'h0);
        check("rst_bist_end",  32'(bus_a.bist_end), 32'h0);
        check("rst_pass_fail", 32'(bus_a.pass_fail), 32'h0);
        check("rst_signature", 32'(bus_a.signature_out), 32'h0);
        check("rst_cbr",       32'(dut_a.cbr), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Mission mode: expected grant queued at drive, popped two clocks later.
        for (int k = 0; k < NV + 2; k++) begin
            @(negedge clock);
            if (k >= 2) begin
                e = exp_q.pop_front();
                check($sformatf("grant_a[%0d]", k - 2), 32'(bus_a.grant_o), 32'(e));
                check($sformatf("grant_b[%0d]", k - 2), 32'(bus_b.grant_o), 32'(e));
            end
            if (k < NV) begin
                req = vecs[k].req;
                exp_q.push_back(vecs[k].grant);
            end else begin
                req = 4'b0000;
            end
        end

        // First BIST run with requests active (must be ignored).
        req = 4'b1111;
        do_reset();
        run_bist(0, lat_a, lat_b);
        check("latency_a", 32'(lat_a), 32'(CYC_A + 2));
        check("latency_b", 32'(lat_b), 32'(CYC_B + 2));
        check("sig_a",     32'(bus_a.signature_out), 32'(s_full));
        check("pf_a",      32'(bus_a.pass_fail), 32'(s_full == GOLD_A));
        check("sig_b",     32'(bus_b.signature_out), 32'(GOLD_B));
        check("sig_b_model", 32'(bus_b.signature_out), 32'(model_sig(CYC_B)));
        check("pf_b",      32'(bus_b.pass_fail), 32'h1);

        // Restart from DONE without reset reseeds and repeats the signature.
        run_bist(0, lat_a, lat_b);
        check("restart_latency_a", 32'(lat_a), 32'(CYC_A + 2));
        check("restart_sig_a",     32'(bus_a.signature_out), 32'(s_full));

        // Five reset/start/end runs; run 2 also pulses start mid-TEST.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            run_bist((r == 2) ? 50 : 0, lat_a, lat_b);
            check($sformatf("run%0d_latency_a", r), 32'(lat_a), 32'(CYC_A + 2));
            check($sformatf("run%0d_sig_a", r),     32'(bus_a.signature_out), 32'(s_full));
            check($sformatf("run%0d_sig_b", r),     32'(bus_b.signature_out), 32'(GOLD_B));
        end

        // Reset during dut_a TEST (dut_b is already DONE with bist_end high).
        do_reset();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(posedge clock);
        check("pre_abort_end_b", 32'(bus_b.bist_end), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_end_a", 32'(bus_a.bist_end), 32'h0);
        check("abort_end_b", 32'(bus_b.bist_end), 32'h0);
        check("abort_pf_b",  32'(bus_b.pass_fail), 32'h0);
        check("abort_sig_b", 32'(bus_b.signature_out), 32'h0);
        check("abort_state", 32'(dut_a.state), 32'(circular_bist_pkg::ST_IDLE));
        @(negedge clock);
        reset = 1'b0;
        run_bist(0, lat_a, lat_b);
        check("post_abort_latency_a", 32'(lat_a), 32'(CYC_A + 2));
        check("post_abort_sig_a",     32'(bus_a.signature_out), 32'(s_full));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
